// File: rtl/rlink_txarb.sv
// rlink transmit byte-channel arbiter: packet-locked round-robin between NREQ
// requesters feeding one registered tx_data/tx_ena stage with downstream hold.
module rlink_txarb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_val,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_eop,
  output logic [NREQ-1:0]   req_hold,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_ena,
  input  logic              tx_hold,
  output logic              busy,
  output logic              tout_err
);

  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW   = ($clog2(TOUT + 1) > 8) ? $clog2(TOUT + 1) : 8;
  localparam logic [CW-1:0] TLIM = CW'((TOUT == 0) ? 0 : TOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [IW-1:0]   rr, rr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [7:0]      tx_data_nxt;
  logic            tx_ena_nxt;
  logic            busy_nxt;
  logic            tout_err_nxt;

  logic            ld_ok;
  logic [NREQ-1:0] acc_vec;
  logic            acc;
  logic [7:0]      sel_data;
  logic            sel_eop;
  logic            sel_val;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   jj;

  // Byte acceptance: only the grantee can load, and only when the output slot frees up
  always_comb begin
    ld_ok    = ~tx_ena | ~tx_hold;
    acc_vec  = grant & req_val & {NREQ{ld_ok}};
    acc      = |acc_vec;
    req_hold = ~acc_vec;
    sel_data = 8'h00;
    sel_eop  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_eop  = req_eop[i];
      end
    end
    sel_val = |(grant & req_val);
  end

  // Round-robin search starting just after the last released owner
  always_comb begin
    found = 1'b0;
    pick  = '0;
    jj    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      jj = IW'((32'(rr) + k) % NREQ);
      if (!found && req_val[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    gidx_nxt     = gidx;
    rr_nxt       = rr;
    cnt_nxt      = cnt;
    tx_data_nxt  = tx_data;
    tx_ena_nxt   = tx_ena;
    busy_nxt     = busy;
    tout_err_nxt = 1'b0;

    if (acc) begin
      tx_data_nxt = sel_data;
      tx_ena_nxt  = 1'b1;
    end else if (!tx_hold) begin
      tx_ena_nxt  = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          gidx_nxt        = pick;
          busy_nxt        = 1'b1;
          cnt_nxt         = '0;
          state_nxt       = S_LOCK;
        end
      end
      default: begin
        if (acc && sel_eop) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          rr_nxt    = gidx;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (sel_val) begin
          cnt_nxt = '0;
        end else if (!ld_ok) begin
          cnt_nxt = cnt;
        end else if ((TOUT != 0) && (cnt == TLIM)) begin
          grant_nxt    = '0;
          busy_nxt     = 1'b0;
          rr_nxt       = gidx;
          cnt_nxt      = '0;
          tout_err_nxt = 1'b1;
          state_nxt    = S_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      gidx     <= '0;
      rr       <= IW'(NREQ - 1);
      cnt      <= '0;
      tx_data  <= 8'h00;
      tx_ena   <= 1'b0;
      busy     <= 1'b0;
      tout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      gidx     <= gidx_nxt;
      rr       <= rr_nxt;
      cnt      <= cnt_nxt;
      tx_data  <= tx_data_nxt;
      tx_ena   <= tx_ena_nxt;
      busy     <= busy_nxt;
      tout_err <= tout_err_nxt;
    end
  end

endmodule

// File: tb/tb_rlink_txarb.sv
// Randomized scoreboard bench for rlink_txarb: packet queues per requester,
// a round-robin packet-order reference model, and a decoupled output monitor.
module tb_rlink_txarb;
  localparam int unsigned NREQ = 4;
  localparam int unsigned TOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_val;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_eop;
  logic [NREQ-1:0]   req_hold;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_ena;
  logic              tx_hold;
  logic              busy;
  logic              tout_err;

  rlink_txarb #(.NREQ(NREQ), .TOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_data(req_data),
    .req_eop(req_eop), .req_hold(req_hold), .grant(grant), .tx_data(tx_data),
    .tx_ena(tx_ena), .tx_hold(tx_hold), .busy(busy), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  logic [7:0] src_b[NREQ][$];
  logic       src_e[NREQ][$];
  logic [7:0] mb[NREQ][$];
  logic       me[NREQ][$];
  logic [7:0] exp_q[$];
  int         exp_g[$];
  int         rr_m;
  int         total = 0;
  int         bad = 0;
  int         tout_cnt = 0;
  int         gap[NREQ];
  logic       acc[NREQ];
  logic       mon_en = 1'b0;
  logic       hold_rand = 1'b0;
  logic       hold_fix = 1'b0;
  logic       gap_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_src(input int i, input logic [7:0] b, input logic e);
    src_b[i].push_back(b);
    src_e[i].push_back(e);
  endtask

  task automatic add_byte(input int i, input logic [7:0] b, input logic e);
    add_src(i, b, e);
    mb[i].push_back(b);
    me[i].push_back(e);
  endtask

  task automatic add_pkt(input int i, input int len);
    for (int n = 0; n < len; n++)
      add_byte(i, 8'($urandom_range(0, 255)), (n == len - 1));
  endtask

  // Reference: whole packets leave in round-robin order over requesters with work queued
  task automatic run_model();
    int  pick;
    bit  found;
    logic e;
    forever begin
      found = 0;
      pick  = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (rr_m + k) % NREQ;
        if (!found && mb[j].size() > 0) begin
          found = 1;
          pick  = j;
        end
      end
      if (!found) break;
      exp_g.push_back(pick);
      e = 1'b0;
      while (!e && mb[pick].size() > 0) begin
        exp_q.push_back(mb[pick].pop_front());
        e = me[pick].pop_front();
      end
      rr_m = pick;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || exp_g.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bytes_left", 32'(exp_q.size()), 0);
    chk("drain_grants_left", 32'(exp_g.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      src_b[i].delete(); src_e[i].delete();
      mb[i].delete(); me[i].delete();
      gap[i] = 0;
    end
    exp_q.delete();
    exp_g.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    clear_all();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    rr_m   = NREQ - 1;
    mon_en = 1'b1;
  endtask

  // Requester driver: present queue heads, advance on accept, random mid-packet gaps
  initial begin
    req_val = '0; req_data = '0; req_eop = '0; tx_hold = 1'b0;
    for (int i = 0; i < NREQ; i++) gap[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) acc[i] = !reset && req_val[i] && !req_hold[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && src_b[i].size() > 0) begin
          logic le;
          le = src_e[i].pop_front();
          void'(src_b[i].pop_front());
          if (gap_en && !le && $urandom_range(0, 2) == 0) gap[i] = $urandom_range(1, 3);
        end
        req_val[i]        = (src_b[i].size() > 0) && (gap[i] == 0);
        req_data[8*i +: 8] = (src_b[i].size() > 0) ? src_b[i][0] : 8'h00;
        req_eop[i]        = (src_e[i].size() > 0) ? src_e[i][0] : 1'b0;
        if (gap[i] > 0) gap[i]--;
      end
      tx_hold = hold_rand ? ($urandom_range(0, 2) == 0) : hold_fix;
    end
  end

  // Output monitor: pops the scoreboard on each downstream transfer and each new grant
  initial begin
    logic            prev_stall;
    logic [7:0]      prev_data;
    logic [NREQ-1:0] prev_grant;
    prev_stall = 1'b0; prev_data = 8'h00; prev_grant = '0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        prev_stall = 1'b0;
        prev_grant = '0;
      end else begin
        if (prev_stall) begin
          chk("stall_ena", 32'(tx_ena), 1);
          chk("stall_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_ena && !tx_hold) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_byte: got %0h expected none", tx_data);
          end else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        if (prev_grant == '0 && grant != '0) begin
          if (exp_g.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_grant: got %0h expected none", grant);
          end else chk("grant_owner", 32'(grant), 32'(1) << exp_g.pop_front());
        end
        if (grant != '0) chk("grant_onehot", 32'($countones(grant)), 1);
        if (tout_err) tout_cnt++;
        prev_stall = tx_ena && tx_hold;
        prev_data  = tx_data;
        prev_grant = grant;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int run;
    reset = 1'b1;
    rr_m  = NREQ - 1;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_tx_ena", 32'(tx_ena), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tout_err", 32'(tout_err), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single requester: grant one cycle after req_val, three back-to-back bytes
    add_byte(1, 8'h11, 1'b0);
    add_byte(1, 8'h22, 1'b0);
    add_byte(1, 8'h33, 1'b1);
    run_model();
    @(negedge clk);
    chk("single_grant_pre", 32'(grant), 0);
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'h2);
    run = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_ena) run++;
    end
    chk("single_run_len", 32'(run), 3);
    chk("single_released", 32'(grant), 0);
    wait_drain(100);

    // Round-robin: continuous 1-byte packets from every requester
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NREQ; i++) add_pkt(i, 1);
    run_model();
    wait_drain(500);

    // Randomized packets, gaps and backpressure
    hold_rand = 1'b1;
    gap_en    = 1'b1;
    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 6));
      end
      add_pkt($urandom_range(0, NREQ - 1), $urandom_range(1, 6));
      run_model();
      wait_drain(3000);
    end
    hold_rand = 1'b0;
    gap_en    = 1'b0;
    chk("no_tout_err", 32'(tout_cnt), 0);

    // Timeout: grantee stops mid-packet, another requester waits
    do_reset();
    tout_cnt = 0;
    add_src(1, 8'hA5, 1'b0);
    exp_g.push_back(1);
    exp_q.push_back(8'hA5);
    n = 0;
    while (!grant[1] && n < 50) begin @(negedge clk); n++; end
    chk("tout_grant1", 32'(grant), 32'h2);
    add_src(3, 8'h3C, 1'b1);
    exp_g.push_back(3);
    exp_q.push_back(8'h3C);
    n = 0;
    while (!(req_val[1] && !req_hold[1]) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!tout_err && n < 40);
    chk("tout_delay", 32'(n), 8);
    chk("tout_grant_clear", 32'(grant), 0);
    chk("tout_busy_clear", 32'(busy), 0);
    @(negedge clk);
    chk("tout_next_grant", 32'(grant), 32'h8);
    chk("tout_err_single", 32'(tout_err), 0);
    rr_m = 3;
    wait_drain(200);
    chk("tout_pulses", 32'(tout_cnt), 1);

    // Reset while a byte is stalled in the output register
    do_reset();
    add_pkt(0, 4);
    run_model();
    n = 0;
    while (!tx_ena && n < 50) begin @(negedge clk); n++; end
    hold_fix = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_stall", 32'(tx_ena && tx_hold), 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    clear_all();
    @(negedge clk);
    chk("mid_rst_tx_ena", 32'(tx_ena), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    reset    = 1'b0;
    hold_fix = 1'b0;
    rr_m     = NREQ - 1;
    for (int i = 0; i < NREQ; i++) add_pkt(i, 1);
    run_model();
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_first_grant", 32'(grant), 32'h1);
    wait_drain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rlink_txarb.md
Name: rlink_txarb

Overview:
- Arbitrates the rlink transmit byte channel between NREQ requesters (e.g. core rlink engine, console/monitor streamers) and drives the single tx_data/tx_ena path into the rlink C-interface or serial port.
- Packet-locked round-robin: a granted requester owns the channel until it sends an end-of-packet byte or goes idle for TOUT cycles.
- One registered output stage; it honours downstream backpressure.

Parameters:
NREQ, 4, number of requesters (2..8).
TOUT, 255, idle cycles of the granted requester before a forced release; 0 disables the timeout.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
req_val  in  NREQ  per-requester byte valid.
req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
req_eop  in  NREQ  byte is the last of a packet; qualified by req_val.
req_hold  out  NREQ  1 = byte not accepted this cycle; requester must keep data stable.
grant  out  NREQ  one-hot current owner; all-zero when idle.
tx_data  out  8  output byte (registered).
tx_ena  out  1  output byte valid (registered).
tx_hold  in  1  downstream backpressure; holds tx_data/tx_ena when 1.
busy  out  1  1 while in LOCK.
tout_err  out  1  one-cycle pulse on a forced timeout release.

Behaviour:
- Reset (synchronous, active-high): grant=0, tx_ena=0, tx_data=0, busy=0, tout_err=0, state=IDLE, idle counter=0, rr pointer=NREQ-1 so requester 0 has priority first.
- Output stage: ld_ok = ~tx_ena | ~tx_hold.
  - Accept for requester i = grant[i] & req_val[i] & ld_ok.
  - On accept: tx_data <= byte, tx_ena <= 1.
  - Else if ~tx_hold: tx_ena <= 0.
  - Else tx_data and tx_ena hold.
- req_hold[i] = ~accept_i. This is combinational from registered state, tx_hold and req_val. Requesters without grant always see req_hold=1.
- Latency: a byte accepted in cycle n appears on tx_data/tx_ena in cycle n+1. Throughput is 1 byte/cycle while tx_hold=0.
- State IDLE:
  - If any req_val is set, pick the first set bit searching from rr+1 upward with wrap-around.
  - grant <= one-hot of that pick; busy <= 1; state <= LOCK.
  - There is 1 cycle of arbitration latency; no byte is accepted in IDLE.
- State LOCK:
  - Accepted byte with req_eop=1: grant <= 0, rr <= granted index, state <= IDLE. The earliest next grant comes 1 cycle later (1 idle gap cycle between packets).
  - Idle counter: cleared whenever the grantee has req_val=1. Stalls from tx_hold do not count as idle. Otherwise the counter increments.
  - If TOUT!=0 and the counter reaches TOUT-1 while incrementing: release as for eop, and tout_err pulses for 1 cycle.
  - The counter is 8 bits wide minimum; it is sized to hold TOUT.
- Releasing a grant never drops a byte already in the output register. That byte drains normally under tx_hold.
- Non-granted req_val and req_eop are ignored. req_eop without req_val is ignored.
- Reset during LOCK, or with tx_ena=1 and tx_hold=1: the pending output byte is discarded (tx_ena=0 next cycle) and all state returns to the reset values.
- Simultaneous eop accept and timeout condition: eop wins; no tout_err.

Test Plan:
- Single requester: req 1 sends 0x11,0x22,0x33(eop) with tx_hold=0 -> grant=0010 one cycle after req_val; tx_ena high 3 consecutive cycles with 0x11,0x22,0x33; then grant=0.
- Round-robin: all 4 requesters send continuous 1-byte eop packets -> grant order 0,1,2,3,0,... with one IDLE cycle between grants.
- Packet lock: req 0 sends a 4-byte packet while req 2 raises req_val at byte 2 -> req_hold[2]=1 throughout; all 4 bytes of req 0 are contiguous; req 2 is granted afterwards.
- Backpressure: tx_hold=1 for 5 cycles mid-packet -> tx_data stays stable, req_hold[g]=1, no byte lost or duplicated, no tout_err.
- Timeout with TOUT=8: the grantee sends 1 byte without eop, then drops req_val -> tout_err pulses once 8 cycles later, grant=0, and another pending requester is granted on the next cycle.
- Reset mid-packet with tx_hold=1 -> next cycle tx_ena=0, grant=0, busy=0; the first grant after reset goes to requester 0 when all requesters are requesting.
